// File: rtl/alu_result_stage.sv
// Result buffer behind the incrementer: a small circular FIFO that stores sum/carry
// with zero/negative flags and presents the head entry combinationally.
module alu_result_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_sum,
    input  logic                     in_carry,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_carry,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     wrap_seen
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = WIDTH + 3;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    // Handshake: a transfer happens on a rising edge only when valid and ready are both
    // high; valid never waits on ready, and a full buffer still accepts when the head
    // leaves in the same cycle.
    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_wrap;
    logic          r_live;

    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;

    assign out_valid = (r_level != '0);
    assign in_ready  = r_live && !clear && ((r_level != FULL) || out_ready);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready && !clear;

    // Entry layout {neg, zero, carry, sum}; flags are fixed at push time.
    assign w_entry = {in_sum[WIDTH-1], ~|in_sum, in_carry, in_sum};
    assign w_head  = r_mem[r_rd_ptr];

    assign out_sum   = out_valid ? w_head[WIDTH-1:0] : '0;
    assign out_carry = out_valid & w_head[WIDTH];
    assign out_zero  = out_valid & w_head[WIDTH+1];
    assign out_neg   = out_valid & w_head[WIDTH+2];
    assign level     = r_level;
    assign wrap_seen = r_wrap;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // r_live holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_wrap   <= 1'b0;
            r_live   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
                r_wrap   <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && in_carry) begin
                    r_wrap <= 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + 1'b1;
                    2'b01:   r_level <= r_level - 1'b1;
                    default: r_level <= r_level;
                endcase
            end
        end
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low; clock port clk, reset port rst_n.
REQ-002 Parameter WIDTH, default 4, SHALL set the result data width.
REQ-003 Parameter DEPTH, default 4, SHALL set the FIFO entry count; legal values are powers of two, 2 to 16.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 clear  input  1  synchronous flush of all stored entries.
REQ-007 in_valid  input  1  upstream incrementer result valid.
REQ-008 in_ready  output  1  stage can accept an entry.
REQ-009 in_sum  input  WIDTH  incrementer sum S.
REQ-010 in_carry  input  1  incrementer carry C_out.
REQ-011 out_valid  output  1  head entry available.
REQ-012 out_ready  input  1  downstream accepts head entry.
REQ-013 out_sum  output  WIDTH  head entry sum.
REQ-014 out_carry  output  1  head entry carry.
REQ-015 out_zero  output  1  head flag: out_sum all zeros.
REQ-016 out_neg  output  1  head flag: out_sum MSB.
REQ-017 level  output  $clog2(DEPTH)+1  count of stored entries.
REQ-018 wrap_seen  output  1  sticky: an accepted entry had in_carry=1.

Function
REQ-019 Push SHALL occur on a rising clk edge when in_valid and in_ready are both 1.
REQ-020 Pop SHALL occur on a rising clk edge when out_valid and out_ready are both 1.
REQ-021 in_ready SHALL be 1 when level<DEPTH, and also when level==DEPTH and out_ready==1 (same-cycle pop frees a slot).
REQ-022 out_valid SHALL equal (level!=0); data SHALL not bypass storage, so latency from push to out_valid is exactly 1 cycle.
REQ-023 out_sum, out_carry, out_zero, out_neg SHALL be driven combinationally from the head entry, and SHALL be held stable while out_valid=1 and out_ready=0.
REQ-024 out_zero and out_neg SHALL be computed at push time from in_sum and stored with the entry.
REQ-025 Storage SHALL be a circular buffer with write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-026 Simultaneous push and pop SHALL leave level unchanged and advance both pointers, including at level==DEPTH and at level==1.
REQ-027 At level==0, out_ready SHALL be ignored: no pop, no pointer move.
REQ-028 At level==DEPTH with out_ready==0, in_valid SHALL be ignored: no push, stored data unchanged.
REQ-029 in_sum/in_carry SHALL be sampled only on push; X values present while in_valid=0 SHALL NOT propagate into storage or flags.
REQ-030 wrap_seen SHALL set on a push with in_carry=1 and SHALL clear only on reset or clear.
REQ-031 clear=1 SHALL, at the next edge, set level=0, both pointers=0, and wrap_seen=0, and SHALL suppress any push or pop in that cycle.
REQ-032 in_ready SHALL be 0 during a cycle in which clear=1.

Reset
REQ-033 rst_n=0 SHALL immediately, without a clock, force level=0, pointers=0, out_valid=0, wrap_seen=0, and in_ready=0.
REQ-034 out_sum, out_carry, out_zero, and out_neg SHALL read 0 while level==0 and during reset; storage contents need not be reset.
REQ-035 in_ready SHALL first go to 1 on the first clk edge after rst_n deasserts.
REQ-036 rst_n asserted mid-transfer SHALL discard all entries; no partial push or pop SHALL be visible after release.

Verification
REQ-037 Reset release, then push sum=4'h7 carry=0 -> next cycle: out_valid=1, out_sum=7, out_zero=0, out_neg=0, level=1.
REQ-038 Push 4'hF, carry=0, then 4'h0 with carry=1, with out_ready=0 -> head is 4'hF with out_neg=1; after one pop, head is 4'h0 with out_zero=1, out_carry=1; wrap_seen=1.
REQ-039 Push 4 entries with out_ready=0 -> level=4, in_ready=0; 5th in_valid is dropped; assert out_ready with in_valid -> in_ready=1 and level stays 4 for 8 cycles; the output sequence matches the input order across pointer wrap.
REQ-040 Pop when empty (out_ready=1, level=0) -> no change, out_valid=0, out_sum=0.
REQ-041 With level=3 and wrap_seen=1, assert clear while in_valid=1 and out_ready=1 -> next cycle: level=0, wrap_seen=0, no entry pushed.
REQ-042 Assert rst_n=0 asynchronously mid-cycle with level=2 -> level=0 and out_valid=0 immediately; after release, in_ready=0 until the first clk edge.
